image_server: RTL
=================

# image_server

Memory-side responder for the column's pixel fetch interface. It holds input images in two ping-pong banks, accepts a new image from an upstream stream while the column processes the current one, and answers the receptive field's `addr` requests with `mem_word`/`data_valid`. Each new image is announced to the column with a one-cycle `addr_clear`. The column's `valid` pulse marks the current image as consumed.

## Interface
- `ADDR_BITS`, `MEM_ADDR_BITS`: word address width.
- `WORD_BITS`, `MEM_WORD_BITS`: memory word width.
- `IMG_HEIGHT`, `IMG_HEIGHT`: image rows.
- `IMG_WIDTH`, `IMG_WIDTH`: image columns.
- `PIXEL_SIZE`, `PIXEL_SIZE`: bits per pixel.
- `IMG_WORDS`, ceil(IMG_HEIGHT*IMG_WIDTH*PIXEL_SIZE/WORD_BITS): words per image; must be ≤ 2^ADDR_BITS (elaboration error otherwise).

Ports:
- `clk`  in  1  clock; one clock domain, everything on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr_valid`  in  1  upstream word valid.
- `wr_data`  in  WORD_BITS  upstream word, in address order 0..IMG_WORDS-1.
- `wr_ready`  out  1  server can accept `wr_data`.
- `addr`  in  ADDR_BITS  word address from the column's receptive field.
- `mem_word`  out  WORD_BITS  read data.
- `data_valid`  out  1  `mem_word` is valid for the previous cycle's `addr`.
- `addr_clear`  out  1  one-cycle pulse: a new image is active; the column restarts fetching.
- `col_valid`  in  1  column finished the active image; release it.
- `serving`  out  1  an image is active (read FSM in SERVE).

## Operation
- Two banks, each with a full flag `full[b]`. There is a write bank pointer `wb` and a read bank pointer `rb`. All are 0 after reset.
- **Write side:**
  - `wr_ready = !full[wb]`, combinational from registered state.
  - A beat is accepted on `wr_valid && wr_ready` and writes `bank[wb][wcnt]`.
  - `wcnt` increments. On the beat with `wcnt == IMG_WORDS-1`, `wcnt` wraps to 0, `full[wb]` is set, and `wb` toggles.
- **Read FSM states:** IDLE, SWAP, SERVE.
  - IDLE: `data_valid=0`. If `full[!rb_last]` is set (the bank after the last released one; initially bank 0), go to SWAP.
  - SWAP: lasts one cycle. Set `rb` to that bank, assert `addr_clear`, then go to SERVE.
  - SERVE: each cycle, sample `addr`. The next cycle gives `mem_word = bank[rb][addr]` and `data_valid = (addr < IMG_WORDS)`. Out-of-range addresses give `data_valid=0` and `mem_word=0`.
  - SERVE on `col_valid`: clear `full[rb]`, then go to SWAP if the other bank is full, else go to IDLE. No read response is issued for an address sampled in the release cycle.
  - `col_valid` outside SERVE is ignored.
- Banks are strictly alternated: images are served in arrival order, and no image is skipped or served twice.
- **Simultaneous events:**
  - If a bank completes a fill in the same cycle that `col_valid` releases the other bank, both take effect.
  - The write path never targets `rb` while SERVE is active, because `full[rb]=1`.
- **Reset mid-operation:** partial fills are discarded, both banks become empty, and the read FSM returns to IDLE. Bank contents need not be cleared.

## Timing
- Reset values: `wr_ready=0` during reset and 1 from the first cycle after; `mem_word=0`, `data_valid=0`, `addr_clear=0`, `serving=0`.
- Read latency is exactly 1 cycle. `mem_word` and `data_valid` are registered, and one response is given per cycle (full throughput).
- Last word of an image accepted at edge k:
  - `full` is visible in cycle k+1, and the FSM is in IDLE→SWAP.
  - `addr_clear` is high in cycle k+2 only.
  - SERVE and `serving` start in cycle k+3.
  - The first `data_valid` can appear in cycle k+4.
- Release to next image, with the other bank full: `col_valid` at edge r, SWAP (`addr_clear`) in cycle r+1, SERVE from cycle r+2.
- `addr_clear` is never asserted for two consecutive cycles.
- `wr_ready` drops in the cycle after the beat that fills the second bank while the first is still served.

## Structure
- Package `tnn_mem_pkg` holds:
  - the `IMG_WORDS` computation function;
  - the read FSM enum (`logic [1:0]`: IDLE, SWAP, SERVE);
  - the bank-index typedef.
- Sub-module `word_ram`: one write port, one registered read port, IMG_WORDS×WORD_BITS. It is instantiated twice, and `rb` muxes the outputs after the register.
- Top level contains the write counter, the full flags, and the read FSM.

## Test plan
Parameters for all scenarios: WORD_BITS=8, IMG 4×4, PIXEL_SIZE=4, so IMG_WORDS=8; ADDR_BITS=4.
- Reset, then stream 8 words 0x10..0x17 back-to-back → `addr_clear` exactly 2 cycles after the last beat; then `addr` 0..7 gives `mem_word` 0x10..0x17 with `data_valid` 1 cycle later each.
- `addr`=8 and `addr`=15 in SERVE → `data_valid=0`, `mem_word=0`.
- Load image A, then image B (0x20..0x27) while serving A; load a third image → `wr_ready` drops after B's last beat; `col_valid` → `addr_clear` next cycle, B served; `wr_ready` returns the cycle after release.
- Last beat of B lands in the same cycle as `col_valid` for A → B is served via SWAP next cycle; no `data_valid` for the release-cycle address.
- `rst_n=0` for 1 cycle after 5 of 8 beats → all outputs at reset values; a fresh 8-word load is served from address 0 with the new data.
- `col_valid` pulsed in IDLE → ignored; `serving` stays 0 and the next loaded image is still served.

Source files
------------

// File: rtl/tnn_mem_pkg.sv
// Shared types for the column-side image memory.
// Holds the read FSM encoding, bank index type and image sizing helper.
package tnn_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWAP,
    SERVE
  } rd_state_e;

  typedef logic bank_t;

  function automatic int img_words_f(
    input int h,
    input int w,
    input int p,
    input int wb
  );
    return (h * w * p + wb - 1) / wb;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Single image bank: one write port, one registered read port.
// Read data holds when re is low.
module word_ram #(
  parameter int IW    = 3,
  parameter int WW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wa,
  input  logic [WW-1:0] wd,
  input  logic          re,
  input  logic [IW-1:0] ra,
  output logic [WW-1:0] rd
);

  logic [WW-1:0] mem_q [DEPTH];
  logic [WW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
    if (re) rd_q <= mem_q[ra];
  end

  assign rd = rd_q;

endmodule

// File: rtl/image_server.sv
// Ping-pong image store feeding the column's receptive field.
// Upstream fills one bank while the column reads the other.
module image_server
  import tnn_mem_pkg::*;
#(
  parameter int ADDR_BITS  = 4,
  parameter int WORD_BITS  = 8,
  parameter int IMG_HEIGHT = 4,
  parameter int IMG_WIDTH  = 4,
  parameter int PIXEL_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  input  logic [WORD_BITS-1:0] wr_data,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] addr,
  output logic [WORD_BITS-1:0] mem_word,
  output logic                 data_valid,
  output logic                 addr_clear,
  input  logic                 col_valid,
  output logic                 serving
);

  localparam int IMG_WORDS =
    img_words_f(IMG_HEIGHT, IMG_WIDTH, PIXEL_SIZE, WORD_BITS);
  localparam int IW = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(IMG_WORDS - 1);
  localparam logic [ADDR_BITS:0] WORDS_W = (ADDR_BITS + 1)'(IMG_WORDS);

  if (IMG_WORDS > 2 ** ADDR_BITS) begin : g_size_chk
    $error("image_server: IMG_WORDS exceeds address space");
  end

  rd_state_e     state_q, state_d;
  logic [IW-1:0] wcnt_q, wcnt_d;
  logic [1:0]    full_q, full_d;
  bank_t         wb_q, wb_d;
  bank_t         rb_q, rb_d;
  bank_t         nxt_q, nxt_d;
  logic          rdy_q;
  logic          dv_q, dv_d;

  logic          wr_fire;
  logic          fill_done;
  logic          in_range;
  logic          nxt_full;
  logic          rd_en;
  logic [WORD_BITS-1:0] rd_word [2];

  assign wr_ready  = rdy_q & ~full_q[wb_q];
  assign wr_fire   = wr_valid & wr_ready;
  assign fill_done = wr_fire & (wcnt_q == LAST);
  assign in_range  = {1'b0, addr} < WORDS_W;
  assign rd_en     = (state_q == SERVE) & ~col_valid & in_range;

  // A fill landing on the release edge still counts as a ready successor.
  assign nxt_full = full_q[nxt_q] | (fill_done & (wb_q == nxt_q));

  always_comb begin
    wcnt_d  = wcnt_q;
    full_d  = full_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    nxt_d   = nxt_q;
    state_d = state_q;
    dv_d    = rd_en;
    if (wr_fire) begin
      wcnt_d = fill_done ? '0 : wcnt_q + 1'b1;
      if (fill_done) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (full_q[nxt_q]) state_d = SWAP;
      end
      SWAP: begin
        rb_d    = nxt_q;
        nxt_d   = ~nxt_q;
        state_d = SERVE;
      end
      SERVE: begin
        if (col_valid) begin
          full_d[rb_q] = 1'b0;
          state_d      = nxt_full ? SWAP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      full_q  <= '0;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      nxt_q   <= 1'b0;
      rdy_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      full_q  <= full_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      nxt_q   <= nxt_d;
      rdy_q   <= 1'b1;
      dv_q    <= dv_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    word_ram #(
      .IW   (IW),
      .WW   (WORD_BITS),
      .DEPTH(IMG_WORDS)
    ) u_ram (
      .clk(clk),
      .we (wr_fire & (wb_q == 1'(b))),
      .wa (wcnt_q),
      .wd (wr_data),
      .re (rd_en & (rb_q == 1'(b))),
      .ra (addr[IW-1:0]),
      .rd (rd_word[b])
    );
  end

  assign mem_word   = dv_q ? rd_word[rb_q] : '0;
  assign data_valid = dv_q;
  assign addr_clear = (state_q == SWAP);
  assign serving    = (state_q == SERVE);

endmodule
